// File: rtl/sum_pkg.sv
// -----------------------------------------------------------------------------
// sum_pkg
// Shared types and constants for the sum_fifo buffering stage.
//   fifo_state_t : occupancy status of the FIFO (EMPTY / PARTIAL / FULL)
//   DROP_W       : width of the dropped-sum counter
//   DROP_MAX     : saturation value of the dropped-sum counter
// No ports (package).
// -----------------------------------------------------------------------------
package sum_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

    localparam int DROP_W   = 8;
    localparam int DROP_MAX = 255;

endpackage

// File: rtl/sum_fifo_if.sv
// -----------------------------------------------------------------------------
// sum_fifo_if
// Bundles the producer strobe, the consumer valid/ready handshake and the
// FIFO status signals of sum_fifo.
//   s, s_valid        : sum from the upstream summer and its strobe
//   q, q_valid, q_ready : head-of-FIFO data and consumer handshake
//   count, full, empty  : occupancy status
//   drops             : saturating count of sums lost while full
//   max               : largest accepted sum (only with SUM_FIFO_MAX_EN)
// Modports: master = producer/consumer side, slave = FIFO side.
// Optional feature macro: SUM_FIFO_MAX_EN.
// -----------------------------------------------------------------------------
interface sum_fifo_if
    import sum_pkg::*;
#(
    parameter int w     = 4,
    parameter int depth = 4
);

    logic [w:0]               s;
    logic                     s_valid;
    logic [w:0]               q;
    logic                     q_valid;
    logic                     q_ready;
    logic [$clog2(depth):0]   count;
    logic                     full;
    logic                     empty;
    logic [DROP_W-1:0]        drops;
`ifdef SUM_FIFO_MAX_EN
    logic [w:0]               max;
`endif

    modport master (
        output s, s_valid, q_ready,
        input  q, q_valid, count, full, empty, drops
`ifdef SUM_FIFO_MAX_EN
        , input max
`endif
    );

    modport slave (
        input  s, s_valid, q_ready,
        output q, q_valid, count, full, empty, drops
`ifdef SUM_FIFO_MAX_EN
        , output max
`endif
    );

endinterface

// File: rtl/sum_fifo_ptr.sv
// -----------------------------------------------------------------------------
// sum_fifo_ptr
// Wrap-around pointer for the sum_fifo storage array. Width is
// $clog2(depth); depth is a power of two, so the natural binary overflow
// gives the modulo-depth wrap.
//   clk   : clock, rising edge
//   rst_b : synchronous active-high reset, pointer returns to 0
//   inc_i : advance the pointer by one at this edge
//   ptr_o : current pointer value
// -----------------------------------------------------------------------------
module sum_fifo_ptr #(
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     inc_i,
    output logic [$clog2(depth)-1:0] ptr_o
);

    localparam int PTR_W = $clog2(depth);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // NOTE: the default assignment before the if keeps this block purely
    // combinational; without it ptr_d would hold its value and infer a latch.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sum_fifo.sv
// -----------------------------------------------------------------------------
// sum_fifo
// First-word-fall-through buffer behind the free-running pair summer. Each
// strobed sum is pushed into a depth-entry register array; the head is
// offered to a consumer over valid/ready. The summer cannot be stalled, so a
// sum arriving while the FIFO is full and not being popped is dropped and
// counted in a saturating 8-bit counter.
//   clk   : clock, rising edge
//   rst_b : synchronous active-high reset (clears pointers, count, storage,
//           drop counter and max)
//   bus   : sum_fifo_if.slave -- s/s_valid in, q/q_valid/q_ready handshake,
//           count/full/empty/drops status out (plus max when enabled)
// Optional feature macro: SUM_FIFO_MAX_EN adds bus.max, the largest sum
// accepted by a push since reset.
// -----------------------------------------------------------------------------
module sum_fifo
    import sum_pkg::*;
#(
    parameter int w     = 4,
    parameter int depth = 4
) (
    input  logic       clk,
    input  logic       rst_b,
    sum_fifo_if.slave  bus
);

    localparam int                PTR_W     = $clog2(depth);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(depth);
    localparam logic [DROP_W-1:0] DROP_SAT  = DROP_W'(DROP_MAX);

    logic [w:0]        mem_q [depth];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drops_q, drops_d;
    fifo_state_t       state_q, state_d;

    logic full;
    logic empty;
    logic q_valid;
    logic push;
    logic pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign q_valid = (state_q != EMPTY);

    // A pop frees the slot that a same-cycle push refills, so a full FIFO
    // still accepts a sum when the consumer is reading.
    assign pop  = q_valid & bus.q_ready;
    assign push = bus.s_valid & (~full | pop);

    sum_fifo_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (clk),
        .rst_b (rst_b),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    sum_fifo_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (clk),
        .rst_b (rst_b),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    // Occupancy, status and drop counter next-state.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        drops_d = drops_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Status moves by at most one step per edge, tracking count.
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop && count_q == DEPTH_CNT - CNT_W'(1)) begin
                    state_d = FULL;
                end else if (pop && !push && count_q == CNT_W'(1)) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop && !push) begin
                    state_d = PARTIAL;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (bus.s_valid && !push && drops_q != DROP_SAT) begin
            drops_d = drops_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            count_q <= '0;
            state_q <= EMPTY;
            drops_q <= '0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            drops_q <= drops_d;
        end
    end

    // NOTE: the storage array is deliberately reset, because q must read 0
    // after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr] <= bus.s;
        end
    end

`ifdef SUM_FIFO_MAX_EN
    logic [w:0] max_q;

    always_ff @(posedge clk) begin
        if (rst_b) begin
            max_q <= '0;
        end else if (push && bus.s > max_q) begin
            max_q <= bus.s;
        end
    end

    assign bus.max = max_q;
`endif

    assign bus.q       = mem_q[rd_ptr];
    assign bus.q_valid = q_valid;
    assign bus.count   = count_q;
    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.drops   = drops_q;

endmodule
